// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial loader: command/reply bytes, FSM state
// encodings and small decode helpers.
package serial_loader_pkg;

    localparam logic [7:0] CMD_LOAD      = 8'h4C;
    localparam logic [7:0] CMD_READ      = 8'h52;
    localparam logic [7:0] CMD_GO        = 8'h47;
    localparam logic [7:0] REPLY_OK      = 8'h4B;
    localparam logic [7:0] REPLY_ERR     = 8'h45;
    localparam logic [7:0] REPLY_HALT    = 8'h48;
    localparam logic [7:0] REPLY_UNKNOWN = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_LOAD_DATA,
        S_LOAD_CSUM,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_CAP,
        S_TX_WAIT,
        S_TX_GAP,
        S_RUN_START,
        S_RUN_WAIT,
        S_REPLY
    } loaderState_e;

    typedef enum logic {
        TXS_READY,
        TXS_GAP
    } txState_e;

    function automatic logic isCommand(input logic [7:0] b);
        return (b == CMD_LOAD) || (b == CMD_READ) || (b == CMD_GO);
    endfunction

    // A length byte of zero stands for a full 256-byte block.
    function automatic logic [8:0] decodeLen(input logic [7:0] b);
        return (b == 8'd0) ? 9'd256 : {1'b0, b};
    endfunction

endpackage

// File: rtl/serial_loader_if.sv
// Bundle of UART, RAM and CPU-control signals between the loader and its
// surroundings; master is the loader side.
interface serial_loader_if #(parameter int ADDR_WIDTH = 9);

    logic [7:0]            rx_byte;
    logic                  received;
    logic [7:0]            tx_byte;
    logic                  transmit;
    logic                  is_transmitting;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [7:0]            dread;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [7:0]            dwrite;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] startaddr;
    logic                  cpu_start;
    logic                  halted;
    logic                  cpu_run;

    modport master (
        input  rx_byte, received, is_transmitting, dread, halted,
        output tx_byte, transmit, raddr, waddr, dwrite, write_en,
               startaddr, cpu_start, cpu_run
    );

    modport slave (
        output rx_byte, received, is_transmitting, dread, halted,
        input  tx_byte, transmit, raddr, waddr, dwrite, write_en,
               startaddr, cpu_start, cpu_run
    );

endinterface

// File: rtl/serial_loader_tx.sv
// UART transmit handshake: while req_i is held, waits for the transmitter to be
// idle, pulses transmit with the byte, then holds one gap cycle.
module serial_loader_tx
    import serial_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       busy_i,
    output logic [7:0] txByte_o,
    output logic       transmit_o
);

    txState_e   state_q, state_d;
    logic [7:0] txByte_q, txByte_d;
    logic       transmit_q, transmit_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= TXS_READY;
            txByte_q   <= 8'd0;
            transmit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            txByte_q   <= txByte_d;
            transmit_q <= transmit_d;
        end
    end

    // The gap cycle gives the transmitter time to raise its busy flag.
    always_comb begin
        state_d    = state_q;
        txByte_d   = txByte_q;
        transmit_d = 1'b0;
        case (state_q)
            TXS_READY: begin
                if (req_i && !busy_i) begin
                    txByte_d   = byte_i;
                    transmit_d = 1'b1;
                    state_d    = TXS_GAP;
                end
            end
            TXS_GAP: state_d = TXS_READY;
            default: state_d = TXS_READY;
        endcase
    end

    assign txByte_o   = txByte_q;
    assign transmit_o = transmit_q;

endmodule

// File: rtl/serial_loader.sv
// Host-side monitor: loads/dumps the shared RAM over UART and starts the CPU.
// Define SERIAL_LOADER_CHECKSUM_EN to add a mod-256 checksum byte to 'L'.
module serial_loader
    import serial_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input logic              clk,
    input logic              rst,
    serial_loader_if.master  bus
);

    loaderState_e          state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [7:0]            addrHi_q, addrHi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            txData_q, txData_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            dwrite_q, dwrite_d;
    logic                  writeEn_q, writeEn_d;
    logic [ADDR_WIDTH-1:0] startAddr_q, startAddr_d;
    logic                  cpuStart_q, cpuStart_d;
    logic                  cpuRun_q, cpuRun_d;

    logic                  rxValid;
    logic                  txReq;
    logic [7:0]            txByte;
    logic                  txPulse;

    // Bytes arriving while the CPU runs belong to the CPU's own input.
    assign rxValid = bus.received && !cpuRun_q;
    assign txReq   = (state_q == S_TX_WAIT);

    serial_loader_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .req_i      (txReq),
        .byte_i     (txData_q),
        .busy_i     (bus.is_transmitting),
        .txByte_o   (txByte),
        .transmit_o (txPulse)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'd0;
            addrHi_q    <= 8'd0;
            addr_q      <= '0;
            len_q       <= 9'd0;
            sum_q       <= 8'd0;
            txData_q    <= 8'd0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            dwrite_q    <= 8'd0;
            writeEn_q   <= 1'b0;
            startAddr_q <= '0;
            cpuStart_q  <= 1'b0;
            cpuRun_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addrHi_q    <= addrHi_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            txData_q    <= txData_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            dwrite_q    <= dwrite_d;
            writeEn_q   <= writeEn_d;
            startAddr_q <= startAddr_d;
            cpuStart_q  <= cpuStart_d;
            cpuRun_q    <= cpuRun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addrHi_d    = addrHi_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sum_d       = sum_q;
        txData_d    = txData_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        dwrite_d    = dwrite_q;
        writeEn_d   = 1'b0;
        startAddr_d = startAddr_q;
        cpuStart_d  = 1'b0;
        cpuRun_d    = cpuRun_q;

        case (state_q)
            S_IDLE: begin
                if (rxValid) begin
                    cmd_d = bus.rx_byte;
                    if (isCommand(bus.rx_byte)) begin
                        state_d = S_ADDR_HI;
                    end else begin
                        txData_d = REPLY_UNKNOWN;
                        state_d  = S_REPLY;
                    end
                end
            end
            S_ADDR_HI: begin
                if (rxValid) begin
                    addrHi_d = bus.rx_byte;
                    state_d  = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (rxValid) begin
                    addr_d  = ADDR_WIDTH'({addrHi_q, bus.rx_byte});
                    state_d = (cmd_q == CMD_GO) ? S_RUN_START : S_LEN;
                end
            end
            S_LEN: begin
                if (rxValid) begin
                    len_d   = decodeLen(bus.rx_byte);
                    sum_d   = 8'd0;
                    state_d = (cmd_q == CMD_LOAD) ? S_LOAD_DATA : S_RD_ADDR;
                end
            end
            S_LOAD_DATA: begin
                if (rxValid) begin
                    waddr_d   = addr_q;
                    dwrite_d  = bus.rx_byte;
                    writeEn_d = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    sum_d     = sum_q + bus.rx_byte;
                    len_d     = len_q - 9'd1;
                    if (len_q == 9'd1) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
                        state_d  = S_LOAD_CSUM;
`else
                        txData_d = REPLY_OK;
                        state_d  = S_REPLY;
`endif
                    end
                end
            end
            S_LOAD_CSUM: begin
                if (rxValid) begin
                    txData_d = (bus.rx_byte == sum_q) ? REPLY_OK : REPLY_ERR;
                    state_d  = S_REPLY;
                end
            end
            // RAM data is valid two cycles after the address is presented.
            S_RD_ADDR: begin
                raddr_d = addr_q;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: state_d = S_RD_CAP;
            S_RD_CAP: begin
                txData_d = bus.dread;
                state_d  = S_TX_WAIT;
            end
            S_REPLY:   state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (txPulse) begin
                    state_d = S_TX_GAP;
                end
            end
            S_TX_GAP: begin
                if ((cmd_q == CMD_READ) && (len_q > 9'd1)) begin
                    len_d   = len_q - 9'd1;
                    addr_d  = addr_q + 1'b1;
                    state_d = S_RD_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN_START: begin
                startAddr_d = addr_q;
                cpuStart_d  = 1'b1;
                cpuRun_d    = 1'b1;
                state_d     = S_RUN_WAIT;
            end
            S_RUN_WAIT: begin
                if (bus.halted) begin
                    cpuRun_d = 1'b0;
                    txData_d = REPLY_HALT;
                    state_d  = S_REPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.tx_byte   = txByte;
    assign bus.transmit  = txPulse;
    assign bus.raddr     = raddr_q;
    assign bus.waddr     = waddr_q;
    assign bus.dwrite    = dwrite_q;
    assign bus.write_en  = writeEn_q;
    assign bus.startaddr = startAddr_q;
    assign bus.cpu_start = cpuStart_q;
    assign bus.cpu_run   = cpuRun_q;

endmodule
